// File: rtl/bp_me_mem_responder_pkg.sv
// bp_me_mem_responder_pkg: message, size and FSM types plus access-size helpers
// shared by the memory responder and its storage.
package bp_me_mem_responder_pkg;

   typedef enum logic [3:0] {
      e_mem_rd    = 4'd0,
      e_mem_wr    = 4'd1,
      e_mem_uc_rd = 4'd2,
      e_mem_uc_wr = 4'd3
   } bp_me_mem_type_e;

   typedef enum logic [2:0] {
      e_size_1   = 3'd0,
      e_size_2   = 3'd1,
      e_size_4   = 3'd2,
      e_size_8   = 3'd3,
      e_size_16  = 3'd4,
      e_size_32  = 3'd5,
      e_size_64  = 3'd6,
      e_size_bad = 3'd7
   } bp_me_mem_size_e;

   typedef struct packed {
      logic [3:0]  msg_type;
      logic [39:0] addr;
      logic [2:0]  size;
      logic [15:0] payload;
   } bp_me_mem_hdr_s;

   typedef enum logic [1:0] {
      e_ready,
      e_wait,
      e_resp
   } state_e;

   // log2 of the access width in bytes; the illegal code acts as a full block
   function automatic logic [2:0] access_lg(input logic [2:0] size);
      return (size == e_size_bad) ? e_size_64 : size;
   endfunction

   function automatic logic type_legal(input logic [3:0] t);
      return t <= e_mem_uc_wr;
   endfunction

   function automatic logic type_write(input logic [3:0] t);
      return (t == e_mem_wr) || (t == e_mem_uc_wr);
   endfunction

endpackage

// File: rtl/bp_me_mem_responder_mem.sv
// bsg_mem_1rw_sync_mask_write_byte: single-port synchronous-read storage with
// per-byte write enables; contents are not reset.
module bsg_mem_1rw_sync_mask_write_byte #(
   parameter int width_p = 512,
   parameter int els_p   = 256
) (
   input  logic                       clk_i,
   input  logic                       v_i,
   input  logic                       w_i,
   input  logic [$clog2(els_p)-1:0]   addr_i,
   input  logic [width_p-1:0]         data_i,
   input  logic [width_p/8-1:0]       write_mask_i,
   output logic [width_p-1:0]         data_o
);

   logic [width_p-1:0] mem [els_p];

   always_ff @(posedge clk_i) begin
      if (v_i & ~w_i) data_o <= mem[addr_i];
      if (v_i & w_i)
         for (int b = 0; b < width_p/8; b++)
            if (write_mask_i[b]) mem[addr_i][8*b +: 8] <= data_i[8*b +: 8];
   end

endmodule

// File: rtl/bp_me_mem_responder.sv
// bp_me_mem_responder: single-outstanding mem_cmd/mem_resp terminator with an
// on-chip byte-maskable backing store and fixed command-to-response latency.
module bp_me_mem_responder
   import bp_me_mem_responder_pkg::*;
#(
   parameter int paddr_width_p    = 40,
   parameter int block_width_p    = 512,
   parameter int payload_width_p  = 16,
   parameter int mem_els_p        = 256,
   parameter int latency_p        = 4,
   parameter int mem_msg_width_lp = 4 + paddr_width_p + 3 + payload_width_p + block_width_p
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic [mem_msg_width_lp-1:0] mem_cmd_i,
   input  logic                        mem_cmd_v_i,
   output logic                        mem_cmd_ready_o,
   output logic [mem_msg_width_lp-1:0] mem_resp_o,
   output logic                        mem_resp_v_o,
   input  logic                        mem_resp_yumi_i,
   output logic                        error_o
);

   localparam int hdr_w   = 4 + paddr_width_p + 3 + payload_width_p;
   localparam int bytes_w = block_width_p / 8;
   localparam int off_w   = $clog2(bytes_w);
   localparam int line_w  = $clog2(mem_els_p);
   localparam int cnt_w   = $clog2(latency_p);

   state_e             state, state_n;
   logic [cnt_w-1:0]   cnt;
   logic               error;
   logic [hdr_w-1:0]   hdr;
   logic [block_width_p-1:0] data;
   logic               accept, mem_v;
   logic [3:0]         cmd_type, msg_type;
   logic [2:0]         cmd_size, size;
   logic [paddr_width_p-1:0] addr;
   logic [off_w:0]     nb;
   logic [off_w-1:0]   off;
   logic [bytes_w-1:0] low_mask, mask;
   logic [block_width_p-1:0] wdata, rd_raw, shifted, rdata;

   assign cmd_type = mem_cmd_i[mem_msg_width_lp-1 -: 4];
   assign cmd_size = mem_cmd_i[block_width_p + payload_width_p +: 3];
   assign msg_type = hdr[hdr_w-1 -: 4];
   assign addr     = hdr[hdr_w-5 -: paddr_width_p];
   assign size     = hdr[payload_width_p +: 3];

   assign mem_cmd_ready_o = reset_n_i & (state == e_ready);
   assign accept          = mem_cmd_v_i & mem_cmd_ready_o;
   assign mem_resp_v_o    = (state == e_resp);
   assign error_o         = error;

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state <= e_ready;
         cnt   <= '0;
         error <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= (state == e_wait) ? cnt + cnt_w'(1) : '0;
         if (accept & (~type_legal(cmd_type) | (cmd_size == e_size_bad))) error <= 1'b1;
      end

   always_ff @(posedge clk_i)
      if (accept) {hdr, data} <= mem_cmd_i;

   always_comb begin
      state_n = state;
      mem_v   = 1'b0;
      case (state)
         e_ready: state_n = accept ? e_wait : e_ready;
         e_wait:
            if (cnt == cnt_w'(latency_p - 2)) begin
               state_n = e_resp;
               mem_v   = type_legal(msg_type);
            end
         e_resp:  state_n = mem_resp_yumi_i ? e_ready : e_resp;
         default: state_n = e_ready;
      endcase
   end

   // Access window: 2^size bytes, aligned down within the block
   assign nb       = (off_w+1)'(1) << access_lg(size);
   assign off      = addr[off_w-1:0] & ~off_w'(nb - (off_w+1)'(1));
   assign low_mask = ~({bytes_w{1'b1}} << nb);
   assign mask     = low_mask << off;
   assign wdata    = data << {off, 3'b000};

   bsg_mem_1rw_sync_mask_write_byte #(
      .width_p(block_width_p),
      .els_p  (mem_els_p)
   ) storage (
      .clk_i       (clk_i),
      .v_i         (mem_v),
      .w_i         (type_write(msg_type)),
      .addr_i      (addr[off_w +: line_w]),
      .data_i      (wdata),
      .write_mask_i(mask),
      .data_o      (rd_raw)
   );

   // Storage output holds while in e_resp, so the response stays stable
   always_comb begin
      shifted = rd_raw >> {off, 3'b000};
      rdata   = '0;
      for (int i = 0; i < bytes_w; i++)
         rdata[8*i +: 8] = shifted[8*(i & (int'(nb) - 1)) +: 8];
   end

   assign mem_resp_o = mem_resp_v_o
      ? {hdr, (type_legal(msg_type) & ~type_write(msg_type)) ? rdata : {block_width_p{1'b0}}}
      : '0;

endmodule

// File: tb/tb_bp_me_mem_responder.sv
// tb_bp_me_mem_responder: directed plus randomized transactions checked against
// a byte-array memory model with immediate assertions.
module tb_bp_me_mem_responder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [574:0] cmd;
   logic         cmd_v, ready, resp_v, yumi, error;
   logic [574:0] resp;
   logic [7:0]   mem_m [256][64];
   logic         exp_err;
   int           n_assert = 0, n_fail = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bp_me_mem_responder dut (
      .clk_i          (clk),
      .reset_n_i      (rst_n),
      .mem_cmd_i      (cmd),
      .mem_cmd_v_i    (cmd_v),
      .mem_cmd_ready_o(ready),
      .mem_resp_o     (resp),
      .mem_resp_v_o   (resp_v),
      .mem_resp_yumi_i(yumi),
      .error_o        (error)
   );

   task automatic chk(input string tag, input logic [574:0] obs, input logic [574:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: apply the command to the byte model, return expected response data
   function automatic logic [511:0] model_op(input logic [3:0] t, input logic [39:0] a,
                                             input logic [2:0] s, input logic [511:0] d);
      logic [511:0] r = '0;
      int nb = (s == 3'd7) ? 64 : (1 << s);
      int off = (int'(a[5:0]) / nb) * nb;
      int line = int'(a[13:6]);
      if (t > 4'd3) return '0;
      if (t == 4'd1 || t == 4'd3) begin
         for (int i = 0; i < nb; i++) mem_m[line][off + i] = d[8*i +: 8];
         return '0;
      end
      for (int j = 0; j < 64; j++) r[8*j +: 8] = mem_m[line][off + (j % nb)];
      return r;
   endfunction

   task automatic xact(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                       input logic [511:0] d, input int hold, input bit cy, output int acc);
      logic [511:0] e;
      logic [15:0]  p;
      logic [574:0] snap;
      int n;
      p = 16'($urandom);
      n = 0;
      while (!ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("ready_idle", ready, 1);
      e = model_op(t, a, s, d);
      if (t > 4'd3 || s == 3'd7) exp_err = 1'b1;
      cmd = {t, a, s, p, d};
      cmd_v = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      cmd_v = 1'b0;
      chk("ready_busy", ready, 0);
      n = 1;
      while (!resp_v && n < 20) begin @(posedge clk); #1; n++; end
      chk("latency", n, 4);
      chk("resp", resp, {t, a, s, p, e});
      chk("error", error, exp_err);
      snap = resp;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_resp", resp, snap);
         chk("hold_v_ready", {resp_v, ready}, 2'b10);
      end
      yumi = 1'b1;
      cmd_v = cy;
      @(posedge clk); #1;
      yumi = 1'b0;
      cmd_v = 1'b0;
      chk("after_yumi", {resp_v, ready}, 2'b01);
   endtask

   initial begin
      logic [511:0] pat, d;
      logic [39:0]  a;
      logic [3:0]   t;
      logic [2:0]   s;
      int a0, a1;
      rst_n = 1'b0; cmd_v = 1'b0; yumi = 1'b0; cmd = '0; exp_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_v", resp_v, 0);
      chk("rst_resp", resp, 0);
      chk("rst_err", error, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", ready, 1);

      xact(4'd1, 40'h48, 3'd3, 512'h1122334455667788, 0, 0, a0);
      xact(4'd0, 40'h48, 3'd3, 512'h0, 0, 0, a0);
      for (int i = 0; i < 64; i++) pat[8*i +: 8] = 8'(i);
      xact(4'd1, 40'h80, 3'd6, pat, 0, 0, a0);
      xact(4'd2, 40'h85, 3'd0, 512'h0, 0, 0, a0);

      xact(4'd0, 40'h48, 3'd3, 512'h0, 0, 0, a0);
      xact(4'd2, 40'h80, 3'd6, 512'h0, 0, 0, a1);
      chk("b2b_spacing", a1 - a0, 5);

      xact(4'd3, 40'hF0_0000_00C4, 3'd2, 512'hDEADBEEF, 7, 1, a0);
      xact(4'd0, 40'hC4, 3'd2, 512'h0, 0, 0, a0);

      xact(4'd7, 40'h48, 3'd3, {16{32'hA5A5_5A5A}}, 0, 0, a0);
      xact(4'd0, 40'h48, 3'd3, 512'h0, 0, 0, a0);
      xact(4'd1, 40'h100, 3'd7, {16{$urandom}}, 0, 0, a0);
      xact(4'd2, 40'h13B, 3'd4, 512'h0, 1, 0, a0);

      // Reset in the middle of a read
      chk("ready_pre_rst", ready, 1);
      cmd = {4'd0, 40'h48, 3'd3, 16'h1, 512'h0};
      cmd_v = 1'b1;
      @(posedge clk); #1;
      cmd_v = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_v_ready_err", {resp_v, ready, error}, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_err = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_midrst", ready, 1);
      xact(4'd0, 40'h48, 3'd3, 512'h0, 0, 0, a0);

      for (int l = 0; l < 8; l++) begin
         for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
         a = {$urandom, 8'h0};
         a[13:0] = {8'(l), 6'h0};
         xact(4'd1, a, 3'd6, d, 0, 0, a0);
      end
      for (int k = 0; k < 60; k++) begin
         for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
         t = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         s = 3'($urandom_range(0, 7));
         a = {$urandom, 8'($urandom)};
         a[13:6] = 8'($urandom_range(0, 7));
         xact(t, a, s, d, $urandom_range(0, 2), 1'($urandom_range(0, 1)), a0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
